// File: rtl/ftdi_latency_timer_if.sv
// ftdi_latency_timer_if
//   Bundles the latency timer's datapath and handshake signals. Member names follow the
//   timer's own port naming, so _i marks a timer input and _o marks a timer output.
//   slave  : the latency timer side (consumes tick/pend/writes/config/ack, drives request).
//   master : the surrounding TX logic side.
//   Members:
//     tick_i        1 ms tick, one clock wide
//     pend_i        TX buffer holds at least one byte
//     data_wr_i     byte written into TX buffer this cycle
//     lat_cfg_i     new latency value, ms
//     lat_cfg_we_i  load lat_cfg_i
//     flush_ack_i   flush completed (pulse)
//     flush_req_o   flush request, held until acknowledged
//     busy_o        timer not idle
//     lat_o         current latency setting
//     flush_cnt_o   timer-triggered flush count (zero unless statistics are built in)
interface ftdi_latency_timer_if #(
    parameter int unsigned LAT_W = 8
);
    logic             tick_i;
    logic             pend_i;
    logic             data_wr_i;
    logic [LAT_W-1:0] lat_cfg_i;
    logic             lat_cfg_we_i;
    logic             flush_ack_i;
    logic             flush_req_o;
    logic             busy_o;
    logic [LAT_W-1:0] lat_o;
    logic [15:0]      flush_cnt_o;

    modport master (
        output tick_i, pend_i, data_wr_i, lat_cfg_i, lat_cfg_we_i, flush_ack_i,
        input  flush_req_o, busy_o, lat_o, flush_cnt_o
    );

    modport slave (
        input  tick_i, pend_i, data_wr_i, lat_cfg_i, lat_cfg_we_i, flush_ack_i,
        output flush_req_o, busy_o, lat_o, flush_cnt_o
    );
endinterface

// File: rtl/ftdi_latency_timer.sv
// ftdi_latency_timer
//   TX-path latency timer. Counts 1 ms ticks while the TX buffer holds data without new
//   writes, and requests a flush once the programmed latency has elapsed. A latency of 0
//   flushes as soon as data is pending.
//   Ports:
//     clk_i  system clock (48 MHz)
//     rst_i  asynchronous active-high reset
//     bus    ftdi_latency_timer_if.slave (tick, pend, write, config, ack in; request,
//            busy, latency, flush count out)
//   Optional feature: define FTDI_LATTMR_STATS_EN to build the saturating flush counter;
//   otherwise flush_cnt_o is tied to zero.
module ftdi_latency_timer #(
    parameter int unsigned LAT_W       = 8,
    parameter int unsigned DEFAULT_LAT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ftdi_latency_timer_if.slave   bus
);
    localparam logic [LAT_W-1:0] DefaultLat = LAT_W'(DEFAULT_LAT);

    typedef enum logic [1:0] {StIdle, StArmed, StFlush} state_e;

    state_e           state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [LAT_W-1:0] ms_q, ms_d;
    logic             flush_req_q, flush_req_d;
    logic             busy_q, busy_d;
    // One bit wider than ms_q so the increment can never wrap.
    logic [LAT_W:0]   ms_inc;

    always_comb begin
        state_d = state_q;
        ms_d    = ms_q;
        lat_d   = bus.lat_cfg_we_i ? bus.lat_cfg_i : lat_q;
        ms_inc  = {1'b0, ms_q} + {{LAT_W{1'b0}}, 1'b1};

        case (state_q)
            StIdle: begin
                if (bus.pend_i) begin
                    if (lat_q != '0) begin
                        state_d = StArmed;
                        ms_d    = '0;
                    end else begin
                        state_d = StFlush;
                    end
                end
            end
            StArmed: begin
                if (!bus.pend_i) begin
                    state_d = StIdle;
                    ms_d    = '0;
                end else if (bus.data_wr_i || bus.lat_cfg_we_i) begin
                    // New data or a new setting restarts the idle window, even on a tick.
                    ms_d = '0;
                end else if (bus.tick_i) begin
                    if (ms_inc == {1'b0, lat_q}) begin
                        state_d = StFlush;
                        ms_d    = '0;
                    end else begin
                        ms_d = ms_inc[LAT_W-1:0];
                    end
                end
            end
            StFlush: begin
                if (bus.flush_ack_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                ms_d    = '0;
            end
        endcase

        // Outputs are registered from the next state so they change only on the clock edge.
        flush_req_d = (state_d == StFlush);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            lat_q       <= DefaultLat;
            ms_q        <= '0;
            flush_req_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            ms_q        <= ms_d;
            flush_req_q <= flush_req_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.flush_req_o = flush_req_q;
    assign bus.busy_o      = busy_q;
    assign bus.lat_o       = lat_q;

`ifdef FTDI_LATTMR_STATS_EN
    logic [15:0] fcnt_q, fcnt_d;

    always_comb begin
        fcnt_d = fcnt_q;
        if ((state_q == StFlush) && bus.flush_ack_i && (fcnt_q != 16'hFFFF)) begin
            fcnt_d = fcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fcnt_q <= 16'd0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign bus.flush_cnt_o = fcnt_q;
`else
    assign bus.flush_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_ftdi_latency_timer.sv
// Testbench for ftdi_latency_timer. Stimulus pushes the expected flush_req_o transitions
// (cycle, level, flush count) into a queue; a monitor compares every observed transition
// against the queue head. Ticks are spaced a few cycles apart rather than 48000 to keep
// the run short; the timer only counts tick pulses, so spacing does not change behaviour.
module tb_ftdi_latency_timer;
    localparam int unsigned TickGap = 6;

    typedef struct {
        string       name;
        int unsigned cyc;
        logic        req;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned exp_cnt = 0;
    exp_t        exp_q[$];

    ftdi_latency_timer_if #(.LAT_W(8)) bus ();

    ftdi_latency_timer #(.LAT_W(8), .DEFAULT_LAT(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Flush count the DUT should report for a given number of completed flushes.
    function automatic logic [15:0] cnt_of(input int unsigned n);
`ifdef FTDI_LATTMR_STATS_EN
        return (n > 32'd65535) ? 16'hFFFF : n[15:0];
`else
        return (n == 0) ? 16'd0 : 16'd0;
`endif
    endfunction

    task automatic check(input string nm, input int unsigned got, input int unsigned want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) step();
    endtask

    // Expect a flush_req_o transition on the next rising edge.
    task automatic expect_ev(input string nm, input logic req);
        exp_t e;
        e.name = nm;
        e.cyc  = cyc + 1;
        e.req  = req;
        e.cnt  = cnt_of(exp_cnt);
        exp_q.push_back(e);
    endtask

    task automatic pulse(input logic t, input logic w, input logic a,
                         input logic ex, input string nm, input logic req);
        bus.tick_i      = t;
        bus.data_wr_i   = w;
        bus.flush_ack_i = a;
        if (ex) expect_ev(nm, req);
        step();
        bus.tick_i      = 1'b0;
        bus.data_wr_i   = 1'b0;
        bus.flush_ack_i = 1'b0;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            gap(TickGap);
            pulse(1'b1, 1'b0, 1'b0, 1'b0, "", 1'b0);
        end
    endtask

    task automatic cfg(input logic [7:0] v);
        bus.lat_cfg_i    = v;
        bus.lat_cfg_we_i = 1'b1;
        step();
        bus.lat_cfg_we_i = 1'b0;
        check("lat_o after config", bus.lat_o, v);
    endtask

    task automatic ack_flush(input string nm);
        bus.pend_i = 1'b0;
        exp_cnt++;
        pulse(1'b0, 1'b0, 1'b1, 1'b1, nm, 1'b0);
        check({nm, " busy_o"}, bus.busy_o, 0);
    endtask

    // Monitor: every flush_req_o transition must match the queue head.
    initial begin
        logic prev_req;
        exp_t e;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.flush_req_o !== prev_req) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected flush_req_o edge: got %b at cycle %0d, expected none",
                             bus.flush_req_o, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.flush_req_o !== e.req || cyc != e.cyc ||
                        bus.flush_cnt_o !== e.cnt || bus.busy_o !== e.req) begin
                        n_bad++;
                        $display("FAIL %s: got req=%b busy=%b cnt=%0d cyc=%0d, expected req=%b busy=%b cnt=%0d cyc=%0d",
                                 e.name, bus.flush_req_o, bus.busy_o, bus.flush_cnt_o, cyc,
                                 e.req, e.req, e.cnt, e.cyc);
                    end
                end
                prev_req = bus.flush_req_o;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.tick_i       = 1'b0;
        bus.pend_i       = 1'b0;
        bus.data_wr_i    = 1'b0;
        bus.lat_cfg_i    = 8'd0;
        bus.lat_cfg_we_i = 1'b0;
        bus.flush_ack_i  = 1'b0;
        gap(3);
        check("reset flush_req_o", bus.flush_req_o, 0);
        check("reset busy_o", bus.busy_o, 0);
        check("reset lat_o", bus.lat_o, 16);
        check("reset flush_cnt_o", bus.flush_cnt_o, 0);
        rst = 1'b0;
        gap(2);

        // Latency 3: request one cycle after the third tick, then acknowledge.
        cfg(8'd3);
        bus.pend_i = 1'b1;
        step();
        check("armed busy_o", bus.busy_o, 1);
        tick_n(2);
        gap(TickGap);
        pulse(1'b1, 1'b0, 1'b0, 1'b1, "lat3 rise", 1'b1);
        gap(3);
        ack_flush("lat3 ack fall");

        // Latency 4: write coincides with third tick, restarting the window.
        cfg(8'd4);
        bus.pend_i = 1'b1;
        step();
        pulse(1'b0, 1'b0, 1'b1, 1'b0, "", 1'b0);  // stray ack while armed
        tick_n(2);
        gap(TickGap);
        pulse(1'b1, 1'b1, 1'b0, 1'b0, "", 1'b0);
        tick_n(3);
        gap(TickGap);
        pulse(1'b1, 1'b0, 1'b0, 1'b1, "lat4 restart rise", 1'b1);
        gap(2);
        ack_flush("lat4 ack fall");

        // Latency 5: buffer empties after two ticks, then a full window is needed.
        cfg(8'd5);
        bus.pend_i = 1'b1;
        step();
        tick_n(2);
        bus.pend_i = 1'b0;
        step();
        check("pend drop busy_o", bus.busy_o, 0);
        bus.pend_i = 1'b1;
        step();
        tick_n(4);
        gap(TickGap);
        pulse(1'b1, 1'b0, 1'b0, 1'b1, "lat5 rearm rise", 1'b1);
        gap(2);
        ack_flush("lat5 ack fall");

        // Latency 0: immediate request; inputs and config in FLUSH do not release it.
        cfg(8'd0);
        bus.pend_i = 1'b1;
        expect_ev("lat0 rise", 1'b1);
        step();
        bus.pend_i = 1'b0;
        gap(2);
        pulse(1'b1, 1'b1, 1'b0, 1'b0, "", 1'b0);
        cfg(8'd7);
        check("flush held after config", bus.flush_req_o, 1);
        ack_flush("lat0 ack fall");

        // Reset while requesting: request drops asynchronously.
        cfg(8'd0);
        bus.pend_i = 1'b1;
        expect_ev("pre-reset rise", 1'b1);
        step();
        gap(2);
        exp_cnt = 0;
        rst = 1'b1;
        expect_ev("reset fall", 1'b0);
        #1;
        check("async reset flush_req_o", bus.flush_req_o, 0);
        check("async reset lat_o", bus.lat_o, 16);
        check("async reset flush_cnt_o", bus.flush_cnt_o, 0);
        check("async reset busy_o", bus.busy_o, 0);
        step();
        bus.pend_i = 1'b0;
        step();
        rst = 1'b0;
        gap(2);

`ifdef FTDI_LATTMR_STATS_EN
        // Counter saturation: preload near the top, then two more flushes.
        force dut.fcnt_q = 16'hFFFE;
        step();
        release dut.fcnt_q;
        exp_cnt = 32'hFFFE;
        check("preload flush_cnt_o", bus.flush_cnt_o, 32'hFFFE);
        cfg(8'd0);
        repeat (2) begin
            bus.pend_i = 1'b1;
            expect_ev("sat rise", 1'b1);
            step();
            gap(1);
            ack_flush("sat ack fall");
        end
        check("saturated flush_cnt_o", bus.flush_cnt_o, 32'hFFFF);
`endif

        gap(4);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending expectations: got %0d left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
